// File: rtl/rv_pkg.sv
// rv_pkg: shared RISC-V integer datapath constants and types
package rv_pkg;
    localparam int XLEN = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_ZERO = 0;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0] xlen_t;
endpackage

// File: rtl/rv_regfile_if.sv
// rv_regfile_if: write port and two read ports of the integer register file
interface rv_regfile_if #(
    parameter int WIDTH = rv_pkg::XLEN,
    parameter int ADDR_W = rv_pkg::REG_ADDR_W
);
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [WIDTH-1:0]  wd;
    logic [ADDR_W-1:0] ra1;
    logic [WIDTH-1:0]  rd1;
    logic [ADDR_W-1:0] ra2;
    logic [WIDTH-1:0]  rd2;
    modport master (output we, wa, wd, ra1, ra2, input rd1, rd2);
    modport slave (input we, wa, wd, ra1, ra2, output rd1, rd2);
endinterface

// File: rtl/rf_wr_decoder.sv
// rf_wr_decoder: one-hot write select, gated by we, entry 0 never selected
module rf_wr_decoder #(
    parameter int DEPTH = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    output logic [DEPTH-1:0]  sel
);
    for (genvar i = 0; i < DEPTH; i++) begin : g_sel
        assign sel[i] = we && (wa == ADDR_W'(i)) && (i != 0);
    end
endmodule

// File: rtl/rv_regfile.sv
// rv_regfile: integer register file, x0 hardwired to zero, two read ports
// with same-cycle write-through bypass
module rv_regfile
    import rv_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int DEPTH = 2 ** REG_ADDR_W,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input logic         clk,
    input logic         rst_n,
    rv_regfile_if.slave bus
);
    logic [DEPTH-1:0] sel;
    logic [WIDTH-1:0] regs [DEPTH-1:1];
    logic [WIDTH-1:0] view [DEPTH];
    logic             byp;
    logic             unused_sel0;

    rf_wr_decoder #(.DEPTH(DEPTH)) u_dec (
        .we (bus.we),
        .wa (bus.wa),
        .sel(sel)
    );

    assign unused_sel0 = sel[0];

    always_ff @(posedge clk) begin
        for (int i = 1; i < DEPTH; i++)
            if (!rst_n) regs[i] <= '0;
            else if (sel[i]) regs[i] <= bus.wd;
    end

    // x0 has no storage; the read view supplies the constant zero
    always_comb begin
        view[0] = '0;
        for (int i = 1; i < DEPTH; i++) view[i] = regs[i];
    end

    assign byp = rst_n && bus.we;

    function automatic logic [WIDTH-1:0] read_port(
        input logic [ADDR_W-1:0] ra,
        input logic [ADDR_W-1:0] wa,
        input logic              b,
        input logic [WIDTH-1:0]  wd,
        input logic [WIDTH-1:0]  stored
    );
        return (ra == ADDR_W'(REG_ZERO)) ? '0 : (b && wa == ra) ? wd : stored;
    endfunction

    assign bus.rd1 = read_port(bus.ra1, bus.wa, byp, bus.wd, view[bus.ra1]);
    assign bus.rd2 = read_port(bus.ra2, bus.wa, byp, bus.wd, view[bus.ra2]);
endmodule

// File: tb/tb_rv_regfile.sv
// tb_rv_regfile: directed vector table, decoder sweep and random regression
// against an array model of the register file
module tb_rv_regfile;
    logic clk = 1'b0;
    logic rst_n;
    int tests = 0;
    int fails = 0;
    logic [31:0] model [32];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        rn;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;
    vec_t vecs [16];

    rv_regfile_if bus ();
    rv_regfile dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [4:0] ra, input logic w, input logic [4:0] a,
                                           input logic [31:0] d, input logic rn);
        if (ra == 5'd0) return 32'd0;
        if (rn && w && a == ra) return d;
        return model[ra];
    endfunction

    // drive one cycle, check reads mid-cycle, then take the edge and update the model
    task automatic step(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic [4:0] r1, input logic [4:0] r2, input logic rn,
                        input logic [31:0] e1, input logic [31:0] e2, input string name);
        bus.we = w;
        bus.wa = a;
        bus.wd = d;
        bus.ra1 = r1;
        bus.ra2 = r2;
        rst_n = rn;
        #3;
        check({name, " rd1"}, bus.rd1, e1);
        check({name, " rd2"}, bus.rd2, e2);
        @(posedge clk);
        if (!rn) foreach (model[i]) model[i] = 32'd0;
        else if (w && a != 5'd0) model[a] = d;
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 5'd0,  32'h0,        5'd5, 5'd0,  1'b0, 32'h0,        32'h0};
        vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5, 5'd6,  1'b1, 32'hDEADBEEF, 32'h0};
        vecs[2]  = '{1'b1, 5'd6,  32'hCAFEF00D, 5'd5, 5'd6,  1'b0, 32'hDEADBEEF, 32'h0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd5, 5'd6,  1'b1, 32'h0,        32'h0};
        vecs[4]  = '{1'b1, 5'd1,  32'h12345678, 5'd0, 5'd0,  1'b1, 32'h0,        32'h0};
        vecs[5]  = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd1, 5'd31, 1'b1, 32'h12345678, 32'hA5A5A5A5};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        5'd1, 5'd31, 1'b1, 32'h12345678, 32'hA5A5A5A5};
        vecs[7]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd1,  1'b1, 32'h0,        32'h12345678};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        5'd0, 5'd31, 1'b1, 32'h0,        32'hA5A5A5A5};
        vecs[9]  = '{1'b1, 5'd7,  32'h11111111, 5'd0, 5'd0,  1'b1, 32'h0,        32'h0};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        5'd7, 5'd7,  1'b1, 32'h11111111, 32'h11111111};
        vecs[11] = '{1'b1, 5'd7,  32'h22222222, 5'd7, 5'd7,  1'b1, 32'h22222222, 32'h22222222};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        5'd7, 5'd7,  1'b1, 32'h22222222, 32'h22222222};
        vecs[13] = '{1'b1, 5'd7,  32'h33333333, 5'd7, 5'd1,  1'b1, 32'h33333333, 32'h12345678};
        vecs[14] = '{1'b1, 5'd7,  32'h44444444, 5'd7, 5'd7,  1'b1, 32'h44444444, 32'h44444444};
        vecs[15] = '{1'b0, 5'd0,  32'h0,        5'd7, 5'd0,  1'b1, 32'h44444444, 32'h0};
        foreach (model[i]) model[i] = 32'd0;
        bus.we = 1'b0;
        bus.wa = 5'd0;
        bus.wd = 32'd0;
        bus.ra1 = 5'd0;
        bus.ra2 = 5'd0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++)
            step(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2, vecs[i].rn,
                 vecs[i].e1, vecs[i].e2, $sformatf("vec%0d", i));
        for (int a = 0; a < 32; a++) begin
            step(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, "dec_rst");
            step(1'b1, 5'(a), 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 32'd0, 32'd0, "dec_wr");
            for (int r = 0; r < 32; r++)
                step(1'b0, 5'd0, 32'd0, 5'(r), 5'(31 - r), 1'b1,
                     (r == a && a != 0) ? 32'hFFFFFFFF : 32'd0,
                     ((31 - r) == a && a != 0) ? 32'hFFFFFFFF : 32'd0,
                     $sformatf("dec%0d_r%0d", a, r));
        end
        for (int n = 0; n < 1000; n++) begin
            logic w, rn;
            logic [4:0] a, r1, r2;
            logic [31:0] d;
            w = 1'($urandom);
            a = 5'($urandom);
            d = $urandom;
            r1 = ($urandom_range(3) == 0) ? a : 5'($urandom);
            r2 = ($urandom_range(3) == 0) ? a : 5'($urandom);
            rn = $urandom_range(99) >= 2;
            step(w, a, d, r1, r2, rn, ref_rd(r1, w, a, d, rn), ref_rd(r2, w, a, d, rn),
                 $sformatf("rnd%0d", n));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
